// File: rtl/mpeg_demux_pkg.sv
// Shared types and constants for the MPEG-1 system-stream demultiplexer.
// Optional DTS decoding is enabled with the MPEG_DEMUX_DTS_EN macro.
package mpeg_demux_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_Z1,
        ST_Z2,
        ST_SC,
        ST_PACK,
        ST_LEN0,
        ST_LEN1,
        ST_HDR,
        ST_STD1,
        ST_PTS,
        ST_DTS,
        ST_BODY,
        ST_SKIP
    } state_t;

    typedef logic [32:0] ts_t;

    localparam logic [7:0] SID_PACK     = 8'hBA;
    localparam logic [7:0] SID_SYS_HDR  = 8'hBB;
    localparam logic [7:0] SID_FIRST_ES = 8'hC0;

    // Fields in stream order: b0[3:1], b1, b2[7:1], b3, b4[7:1].
    function automatic ts_t ts_assemble(input logic [2:0] f0, input logic [7:0] f1,
                                        input logic [6:0] f2, input logic [7:0] f3,
                                        input logic [6:0] f4);
        return {f0, f1, f2, f3, f4};
    endfunction

endpackage

// File: rtl/mpeg_demux_ts_parser.sv
// Five-byte PTS/DTS assembler; marker bits live in bit 0 of bytes 0, 2 and 4.
// ts is valid together with done on the byte at index 4.
module mpeg_ts_parser
    import mpeg_demux_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ts_valid,
    input  logic [2:0]  ts_idx,
    input  logic [7:0]  ts_byte,
    output logic [32:0] ts,
    output logic        done,
    output logic        err
);

    logic [2:0] f0;
    logic [7:0] f1;
    logic [6:0] f2;
    logic [7:0] f3;
    logic       marker_pos;
    logic       marker_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            f0 <= '0;
            f1 <= '0;
            f2 <= '0;
            f3 <= '0;
        end else if (ts_valid) begin
            case (ts_idx)
                3'd0:    f0 <= ts_byte[3:1];
                3'd1:    f1 <= ts_byte;
                3'd2:    f2 <= ts_byte[7:1];
                3'd3:    f3 <= ts_byte;
                default: ;
            endcase
        end
    end

    assign marker_pos = (ts_idx == 3'd0) || (ts_idx == 3'd2) || (ts_idx == 3'd4);
    assign marker_bad = ts_valid && marker_pos && !ts_byte[0];
    assign err        = marker_bad;
    assign done       = ts_valid && (ts_idx == 3'd4) && !marker_bad;
    assign ts         = ts_assemble(f0, f1, f2, f3, ts_byte[7:1]);

endmodule

// File: rtl/mpeg_multi_demuxer.sv
// Multi-channel MPEG-1 system-stream demultiplexer with per-channel start time.
// Define MPEG_DEMUX_DTS_EN to decode DTS and expose dts_valid/dts.
//
// state   | meaning
// IDLE    | start-code search, no zeros seen
// Z1/Z2   | one / two-or-more 00 bytes seen
// SC      | next byte is the stream_id
// PACK    | 8 pack-header bytes (SCR + mux rate), idx counts
// LEN0/1  | packet length high / low byte
// HDR     | PES header: stuffing, STD, timestamp selector
// STD1    | second STD buffer byte
// PTS/DTS | timestamp bytes, idx counts 0..4
// BODY    | payload bytes to the decoder
// SKIP    | drop remaining packet bytes by length
module mpeg_multi_demuxer
    import mpeg_demux_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           mpeg_data,
    input  logic                 data_valid,
    input  logic [31:0]          dclk,
    input  logic [NUM_CH*8-1:0]  filter_id,
    input  logic [NUM_CH-1:0]    filter_en,
    output logic                 body_valid,
    output logic [7:0]           body_data,
    output logic [CH_W-1:0]      body_ch,
    output logic                 body_last,
    output logic                 pts_valid,
    output logic [CH_W-1:0]      pts_ch,
    output logic [32:0]          pts,
    output logic [32:0]          scr,
    output logic [NUM_CH*33-1:0] start_time,
`ifdef MPEG_DEMUX_DTS_EN
    output logic                 dts_valid,
    output logic [32:0]          dts,
`endif
    output logic [NUM_CH-1:0]    start_time_valid
);

    state_t          state;
    logic [15:0]     len;
    logic [7:0]      len_hi;
    logic [2:0]      idx;
    logic            pkt_match;
    logic [CH_W-1:0] pkt_ch;
    logic            has_dts;
    logic [2:0]      pack_f0;
    logic [7:0]      pack_f1;
    logic [6:0]      pack_f2;
    logic [7:0]      pack_f3;

    logic            match_hit;
    logic [CH_W-1:0] match_ch;
    logic            hdr_ts_start;
    logic            ts_valid;
    logic [2:0]      ts_idx;
    ts_t             ts;
    logic            ts_done;
    logic            ts_err;
    logic            counted;
    logic            last_byte;
    logic [31:0]     st_new;

    // Lowest matching index wins when several filters carry the same stream_id.
    always_comb begin
        match_hit = 1'b0;
        match_ch  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (filter_en[i] && (filter_id[i*8 +: 8] == mpeg_data)) begin
                match_hit = 1'b1;
                match_ch  = CH_W'(i);
            end
        end
    end

    assign hdr_ts_start = (mpeg_data[7:5] == 3'b001) && mpeg_data[0];

    always_comb begin
        ts_valid = 1'b0;
        ts_idx   = idx;
        if (data_valid) begin
            case (state)
                ST_HDR: begin
                    ts_valid = hdr_ts_start;
                    ts_idx   = 3'd0;
                end
                ST_PTS:  ts_valid = 1'b1;
`ifdef MPEG_DEMUX_DTS_EN
                ST_DTS:  ts_valid = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    mpeg_ts_parser u_ts_parser (
        .clk      (clk),
        .reset    (reset),
        .ts_valid (ts_valid),
        .ts_idx   (ts_idx),
        .ts_byte  (mpeg_data),
        .ts       (ts),
        .done     (ts_done),
        .err      (ts_err)
    );

    assign counted   = (state == ST_HDR) || (state == ST_STD1) || (state == ST_PTS) ||
                       (state == ST_DTS) || (state == ST_BODY) || (state == ST_SKIP);
    assign last_byte = (len == 16'd1);
    assign st_new    = dclk + ts[32:1] - scr[32:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            len              <= '0;
            len_hi           <= '0;
            idx              <= '0;
            pkt_match        <= 1'b0;
            pkt_ch           <= '0;
            has_dts          <= 1'b0;
            pack_f0          <= '0;
            pack_f1          <= '0;
            pack_f2          <= '0;
            pack_f3          <= '0;
            body_valid       <= 1'b0;
            body_data        <= '0;
            body_ch          <= '0;
            body_last        <= 1'b0;
            pts_valid        <= 1'b0;
            pts_ch           <= '0;
            pts              <= '0;
            scr              <= '0;
            start_time       <= '0;
            start_time_valid <= '0;
`ifdef MPEG_DEMUX_DTS_EN
            dts_valid        <= 1'b0;
            dts              <= '0;
`endif
        end else begin
            body_valid <= 1'b0;
            body_last  <= 1'b0;
            pts_valid  <= 1'b0;
`ifdef MPEG_DEMUX_DTS_EN
            dts_valid  <= 1'b0;
`endif
            if (data_valid) begin
                case (state)
                    ST_IDLE: state <= (mpeg_data == 8'h00) ? ST_Z1 : ST_IDLE;
                    ST_Z1:   state <= (mpeg_data == 8'h00) ? ST_Z2 : ST_IDLE;
                    ST_Z2: begin
                        if (mpeg_data == 8'h01)      state <= ST_SC;
                        else if (mpeg_data != 8'h00) state <= ST_IDLE;
                    end
                    ST_SC: begin
                        idx <= 3'd0;
                        if (mpeg_data == SID_PACK) begin
                            state <= ST_PACK;
                        end else if (mpeg_data >= SID_SYS_HDR) begin
                            state     <= ST_LEN0;
                            pkt_match <= match_hit && (mpeg_data >= SID_FIRST_ES);
                            pkt_ch    <= match_ch;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_PACK: begin
                        case (idx)
                            3'd0:    pack_f0 <= mpeg_data[3:1];
                            3'd1:    pack_f1 <= mpeg_data;
                            3'd2:    pack_f2 <= mpeg_data[7:1];
                            3'd3:    pack_f3 <= mpeg_data;
                            3'd4:    scr <= ts_assemble(pack_f0, pack_f1, pack_f2, pack_f3,
                                                        mpeg_data[7:1]);
                            default: ;
                        endcase
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= ST_IDLE;
                    end
                    ST_LEN0: begin
                        len_hi <= mpeg_data;
                        state  <= ST_LEN1;
                    end
                    ST_LEN1: begin
                        len <= {len_hi, mpeg_data};
                        if ({len_hi, mpeg_data} == 16'd0) state <= ST_IDLE;
                        else if (pkt_match)               state <= ST_HDR;
                        else                              state <= ST_SKIP;
                    end
                    ST_HDR: begin
                        if (mpeg_data == 8'hFF) begin
                            state <= ST_HDR;
                        end else if (mpeg_data[7:6] == 2'b01) begin
                            state <= ST_STD1;
                        end else if (hdr_ts_start) begin
                            state   <= ST_PTS;
                            idx     <= 3'd1;
                            has_dts <= mpeg_data[4];
                        end else if (mpeg_data == 8'h0F) begin
                            state <= ST_BODY;
                        end else begin
                            state <= ST_SKIP;
                        end
                    end
                    ST_STD1: state <= ST_HDR;
                    ST_PTS: begin
                        if (ts_err) begin
                            state <= ST_SKIP;
                        end else if (ts_done) begin
                            pts_valid <= 1'b1;
                            pts       <= ts;
                            pts_ch    <= pkt_ch;
                            for (int i = 0; i < NUM_CH; i++) begin
                                if ((pkt_ch == CH_W'(i)) && !start_time_valid[i]) begin
                                    start_time_valid[i]     <= 1'b1;
                                    start_time[i*33 +: 33]  <= {st_new, 1'b0};
                                end
                            end
                            idx   <= 3'd0;
                            state <= has_dts ? ST_DTS : ST_BODY;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                    ST_DTS: begin
`ifdef MPEG_DEMUX_DTS_EN
                        if (ts_err) begin
                            state <= ST_SKIP;
                        end else if (ts_done) begin
                            dts_valid <= 1'b1;
                            dts       <= ts;
                            state     <= ST_BODY;
                        end else begin
                            idx <= idx + 3'd1;
                        end
`else
                        if (idx == 3'd4) state <= ST_BODY;
                        else             idx <= idx + 3'd1;
`endif
                    end
                    ST_BODY: begin
                        body_valid <= 1'b1;
                        body_data  <= mpeg_data;
                        body_ch    <= pkt_ch;
                        body_last  <= last_byte;
                    end
                    ST_SKIP: ;
                    default: state <= ST_IDLE;
                endcase
                // Every byte after LEN1 consumes length; the final one ends the packet.
                if (counted) begin
                    len <= len - 16'd1;
                    if (last_byte) state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mpeg_multi_demuxer.sv
// Randomised bench for mpeg_multi_demuxer: packets are generated from a
// description and the expected strobes/timestamps are derived from that description.
module tb_mpeg_multi_demuxer;

    localparam int NUM_CH = 2;
    localparam int CH_W   = 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [7:0]           mpeg_data = 8'h00;
    logic                 data_valid = 1'b0;
    logic [31:0]          dclk = 32'd0;
    logic [NUM_CH*8-1:0]  filter_id = {8'hE0, 8'hC0};
    logic [NUM_CH-1:0]    filter_en = 2'b11;
    logic                 body_valid;
    logic [7:0]           body_data;
    logic [CH_W-1:0]      body_ch;
    logic                 body_last;
    logic                 pts_valid;
    logic [CH_W-1:0]      pts_ch;
    logic [32:0]          pts;
    logic [32:0]          scr;
    logic [NUM_CH*33-1:0] start_time;
    logic [NUM_CH-1:0]    start_time_valid;
`ifdef MPEG_DEMUX_DTS_EN
    logic                 dts_valid;
    logic [32:0]          dts;
`endif

    always #5 clk = ~clk;

    mpeg_multi_demuxer #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .mpeg_data        (mpeg_data),
        .data_valid       (data_valid),
        .dclk             (dclk),
        .filter_id        (filter_id),
        .filter_en        (filter_en),
        .body_valid       (body_valid),
        .body_data        (body_data),
        .body_ch          (body_ch),
        .body_last        (body_last),
        .pts_valid        (pts_valid),
        .pts_ch           (pts_ch),
        .pts              (pts),
        .scr              (scr),
        .start_time       (start_time),
`ifdef MPEG_DEMUX_DTS_EN
        .dts_valid        (dts_valid),
        .dts              (dts),
`endif
        .start_time_valid (start_time_valid)
    );

    typedef struct packed {
        logic [7:0]      data;
        logic [CH_W-1:0] ch;
        logic            last;
    } body_ev_t;

    typedef struct packed {
        logic [32:0]     val;
        logic [CH_W-1:0] ch;
    } pts_ev_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    body_ev_t    exp_body[$];
    pts_ev_t     exp_pts[$];
    logic [32:0] m_scr = '0;
    logic [32:0] m_st [NUM_CH];
    logic [NUM_CH-1:0] m_st_valid = '0;
    bit          gaps = 1'b0;
    logic [7:0]  id_pool  [4] = '{8'hC0, 8'hC1, 8'hE0, 8'hE1};
    logic [7:0]  sid_pool [6] = '{8'hC0, 8'hC1, 8'hE0, 8'hE1, 8'hBD, 8'hBB};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (body_valid) begin
                if (exp_body.size() == 0) begin
                    check_val("body_extra", 64'(exp_body.size()), 64'd1);
                end else begin
                    body_ev_t e;
                    e = exp_body.pop_front();
                    check_val("body_data", body_data, e.data);
                    check_val("body_ch", body_ch, e.ch);
                    check_val("body_last", body_last, e.last);
                end
            end
            if (pts_valid) begin
                if (exp_pts.size() == 0) begin
                    check_val("pts_extra", 64'(exp_pts.size()), 64'd1);
                end else begin
                    pts_ev_t p;
                    p = exp_pts.pop_front();
                    check_val("pts_val", pts, p.val);
                    check_val("pts_ch", pts_ch, p.ch);
                end
            end
        end
    end

    function automatic int ref_channel(input logic [7:0] sid);
        int ch;
        ch = -1;
        if (sid >= 8'hC0)
            for (int i = 0; i < NUM_CH; i++)
                if (ch < 0 && filter_en[i] && filter_id[i*8 +: 8] == sid) ch = i;
        return ch;
    endfunction

    task automatic push_body(input logic [7:0] d, input int ch, input logic last);
        body_ev_t e;
        e.data = d;
        e.ch   = CH_W'(ch);
        e.last = last;
        exp_body.push_back(e);
    endtask

    task automatic emit_pts(input int ch, input logic [32:0] v);
        pts_ev_t e;
        e.val = v;
        e.ch  = CH_W'(ch);
        exp_pts.push_back(e);
        if (!m_st_valid[ch]) begin
            m_st_valid[ch] = 1'b1;
            m_st[ch] = {dclk + v[32:1] - m_scr[32:1], 1'b0};
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
        @(negedge clk);
        mpeg_data  = b;
        data_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            data_valid = 1'b0;
        end
    endtask

    task automatic send_sc(input logic [7:0] sid);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(sid);
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_scr"}, scr, m_scr);
        check_val({tag, "_stv"}, start_time_valid, m_st_valid);
        for (int i = 0; i < NUM_CH; i++)
            check_val({tag, "_st"}, start_time[i*33 +: 33], m_st[i]);
    endtask

    task automatic ts_encode(input logic [3:0] pfx, input logic [32:0] v, output logic [7:0] b [5]);
        b[0] = {pfx, v[32:30], 1'b1};
        b[1] = v[29:22];
        b[2] = {v[21:15], 1'b1};
        b[3] = v[14:7];
        b[4] = {v[6:0], 1'b1};
    endtask

    task automatic send_pack(input logic [32:0] s);
        logic [7:0] b [5];
        ts_encode(4'b0010, s, b);
        send_sc(8'hBA);
        for (int k = 0; k < 5; k++) send_byte(b[k]);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom));
        m_scr = s;
        idle(3);
        check_val("pack_scr", scr, m_scr);
    endtask

    // ts_mode: 0 plain, 1 PTS, 2 PTS+DTS. bad: 1..3 corrupt PTS marker 0/2/4, 4 DTS marker 2.
    task automatic send_pes(input logic [7:0] sid, input int n_stuff, input bit std,
                            input int ts_mode, input int bad, input int n_pay);
        logic [7:0]  hdr[$];
        logic [7:0]  pay[$];
        logic [7:0]  pb [5];
        logic [7:0]  db [5];
        logic [32:0] pv;
        int          ch;
        int          len;
        bit          ok;
        pv = 33'({$urandom, $urandom});
        repeat (n_stuff) hdr.push_back(8'hFF);
        if (std) begin
            hdr.push_back(8'h40 | 8'($urandom_range(0, 63)));
            hdr.push_back(8'($urandom));
        end
        if (ts_mode == 0) begin
            hdr.push_back(8'h0F);
        end else begin
            ts_encode((ts_mode == 2) ? 4'b0011 : 4'b0010, pv, pb);
            if (bad == 1) pb[0][0] = 1'b0;
            if (bad == 2) pb[2][0] = 1'b0;
            if (bad == 3) pb[4][0] = 1'b0;
            for (int k = 0; k < 5; k++) hdr.push_back(pb[k]);
            if (ts_mode == 2) begin
                ts_encode(4'b0001, 33'({$urandom, $urandom}), db);
                if (bad == 4) db[2][0] = 1'b0;
                for (int k = 0; k < 5; k++) hdr.push_back(db[k]);
            end
        end
        for (int k = 0; k < n_pay; k++) pay.push_back(8'($urandom));
        len = hdr.size() + n_pay;
        ch  = ref_channel(sid);
        if (ch >= 0) begin
            ok = 1'b1;
            if (ts_mode != 0) begin
                if (bad >= 1 && bad <= 3) ok = 1'b0;
                else emit_pts(ch, pv);
`ifdef MPEG_DEMUX_DTS_EN
                if (ts_mode == 2 && bad == 4) ok = 1'b0;
`endif
            end
            if (ok)
                for (int k = 0; k < n_pay; k++) push_body(pay[k], ch, k == n_pay - 1);
        end
        send_sc(sid);
        send_byte(8'(len >> 8));
        send_byte(8'(len));
        foreach (hdr[k]) send_byte(hdr[k]);
        foreach (pay[k]) send_byte(pay[k]);
        idle(4);
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) m_st[i] = '0;
        idle(4);
        check_val("rst_body_valid", body_valid, 0);
        check_val("rst_body_last", body_last, 0);
        check_val("rst_pts_valid", pts_valid, 0);
        check_val("rst_pts", pts, 0);
        check_state("rst");
        reset = 1'b0;
        idle(2);

        // Pack header: scr follows the PACK4 byte.
        send_sc(8'hBA);
        send_byte(8'h21); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        check_val("scr_before_pack4", scr, 0);
        send_byte(8'h05);
        idle(1);
        check_val("scr_after_pack4", scr, 33'd2);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        m_scr = 33'd2;
        idle(3);

        // Audio packet with PTS: three payload bytes on ch0.
        dclk = 32'd1000;
        push_body(8'h00, 0, 1'b0);
        push_body(8'hAA, 0, 1'b0);
        push_body(8'hBB, 0, 1'b1);
        emit_pts(0, 33'd2);
        send_sc(8'hC0);
        send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h21); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        idle(4);
        check_val("audio_start_time", start_time[32:0], 33'd2000);
        check_state("audio");

        // Unmatched packet carrying a start-code emulation, then a real E0 packet on ch1.
        send_sc(8'hC1);
        send_byte(8'h00); send_byte(8'h06);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hE0); send_byte(8'h00); send_byte(8'h00);
        idle(3);
        dclk = 32'd77;
        send_pes(8'hE0, 0, 1'b0, 1, 0, 3);
        check_state("video");

        // Both filters on E0: lowest channel wins.
        filter_id = {8'hE0, 8'hE0};
        send_pes(8'hE0, 1, 1'b1, 0, 0, 4);
        filter_id = {8'hE0, 8'hC0};

        // Bad marker in the first PTS byte drops the packet; the next one parses.
        send_sc(8'hC0);
        send_byte(8'h00); send_byte(8'h08);
        send_byte(8'h20); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB);
        idle(3);
        send_pes(8'hC0, 0, 1'b0, 1, 0, 2);

        // Length boundaries: zero length, and 0F as the final byte.
        send_sc(8'hC0);
        send_byte(8'h00); send_byte(8'h00);
        send_pes(8'hC0, 0, 1'b0, 0, 0, 0);
        send_pes(8'hE0, 0, 1'b0, 0, 0, 1);

        // Randomised traffic.
        gaps = 1'b1;
        for (int n = 0; n < 80; n++) begin
            int ts_mode;
            if (n % 8 == 0) begin
                filter_id = {id_pool[$urandom_range(0, 3)], id_pool[$urandom_range(0, 3)]};
                filter_en = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 4) == 0) send_byte(($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF);
            if ($urandom_range(0, 4) == 0) begin
                send_pack(33'({$urandom, $urandom}));
            end else begin
                dclk    = $urandom;
                ts_mode = $urandom_range(0, 2);
                send_pes(sid_pool[$urandom_range(0, 5)], $urandom_range(0, 2),
                         1'($urandom_range(0, 1)), ts_mode,
                         ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                         (ts_mode != 0) ? $urandom_range(1, 6) : $urandom_range(0, 6));
            end
            check_state("rand");
        end
        gaps = 1'b0;

        // Reset in the middle of a body drops the rest of that packet.
        filter_id = {8'hE0, 8'hC0};
        filter_en = 2'b11;
        push_body(8'h11, 0, 1'b0);
        push_body(8'h22, 0, 1'b0);
        push_body(8'h33, 0, 1'b0);
        send_sc(8'hC0);
        send_byte(8'h00); send_byte(8'h07);
        send_byte(8'h0F); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        idle(3);
        reset = 1'b1;
        idle(3);
        m_scr      = '0;
        m_st_valid = '0;
        for (int i = 0; i < NUM_CH; i++) m_st[i] = '0;
        check_state("mid_reset");
        reset = 1'b0;
        idle(2);
        dclk = 32'd5000;
        send_pes(8'hC0, 0, 1'b0, 1, 0, 3);
        check_state("after_reset");
        dclk = 32'd9999;
        send_pes(8'hC0, 0, 1'b0, 2, 0, 2);
        check_state("second_pts");

        idle(5);
        check_val("body_pending", 64'(exp_body.size()), 64'd0);
        check_val("pts_pending", 64'(exp_pts.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
